// File: rtl/gps_pkg.sv
// Shared sample and word types for the GPS capture path.
package gps_pkg;

    typedef logic [2:0] gps_iq3_t;

    typedef struct packed {
        gps_iq3_t imag;
        gps_iq3_t real_v;
    } gps_iq_sample_t;

    localparam int SAMPLES_PER_WORD = 5;
    localparam int PACK_WORD_W      = 32;
    localparam int SEQ_W            = 2;
    localparam int SAMPLE_W         = $bits(gps_iq_sample_t);
    localparam int PART_W           = (SAMPLES_PER_WORD - 1) * SAMPLE_W;

    // Assemble {seq, last sample, earlier samples} into one packed word.
    function automatic logic [PACK_WORD_W-1:0] pack_word(input logic [SEQ_W-1:0] seq,
                                                         input gps_iq_sample_t last,
                                                         input logic [PART_W-1:0] part);
        return {seq, last, part};
    endfunction

endpackage

// File: rtl/gps_word_fifo.sv
// Synchronous first-word-fall-through FIFO; head word is visible whenever not empty.
module gps_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    output logic                       full,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];
    assign count    = count_q;

endmodule

// File: rtl/gps_sample_packer.sv
// Decimates 3-bit I/Q samples, packs five per 32-bit word with a sequence tag, and buffers them.
// Define GPS_PACKER_STATS_EN to implement the saturating dropped-word counter.
module gps_sample_packer
    import gps_pkg::*;
#(
    parameter int DECIM      = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic [2:0]                    real_in,
    input  logic [2:0]                    imag_in,
    output logic [31:0]                   m_data,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fill_level,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [15:0]                   dropped_cnt
);

    localparam int DW = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [2:0] LAST_SLOT = 3'(SAMPLES_PER_WORD - 1);

    gps_iq_sample_t         sample;
    logic [DW-1:0]          decim_cnt_q, decim_cnt_d;
    logic [2:0]             slot_q, slot_d;
    logic [SEQ_W-1:0]       seq_q, seq_d;
    logic [PART_W-1:0]      part_q, part_d;
    logic [PACK_WORD_W-1:0] word_q, word_d;
    logic                   push_q, push_d;
    logic                   overflow_q, overflow_d;
    logic                   keep;
    logic                   fifo_full, fifo_empty, fifo_pop, drop;

    assign sample = {imag_in, real_in};

    always_comb begin
        decim_cnt_d = decim_cnt_q;
        slot_d      = slot_q;
        seq_d       = seq_q;
        part_d      = part_q;
        word_d      = word_q;
        push_d      = 1'b0;
        keep        = 1'b0;
        if (!enable) begin
            // Partial word is abandoned; seq and the FIFO are left alone.
            decim_cnt_d = '0;
            slot_d      = '0;
        end else begin
            keep        = (decim_cnt_q == '0);
            decim_cnt_d = (decim_cnt_q == DW'(DECIM - 1)) ? '0 : decim_cnt_q + DW'(1);
            if (keep) begin
                if (slot_q == LAST_SLOT) begin
                    word_d = pack_word(seq_q, sample, part_q);
                    push_d = 1'b1;
                    slot_d = '0;
                    seq_d  = seq_q + SEQ_W'(1);
                end else begin
                    part_d[int'(slot_q) * SAMPLE_W +: SAMPLE_W] = sample;
                    slot_d = slot_q + 3'd1;
                end
            end
        end
    end

    assign fifo_pop = m_valid && m_ready;
    assign drop     = push_q && fifo_full && !fifo_pop;

    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            decim_cnt_q <= '0;
            slot_q      <= '0;
            seq_q       <= '0;
            part_q      <= '0;
            word_q      <= '0;
            push_q      <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            decim_cnt_q <= decim_cnt_d;
            slot_q      <= slot_d;
            seq_q       <= seq_d;
            part_q      <= part_d;
            word_q      <= word_d;
            push_q      <= push_d;
            overflow_q  <= overflow_d;
        end
    end

`ifdef GPS_PACKER_STATS_EN
    logic [15:0] dropped_q, dropped_d;

    always_comb begin
        dropped_d = dropped_q;
        if (drop && (dropped_q != 16'hFFFF)) begin
            dropped_d = dropped_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dropped_q <= '0;
        end else begin
            dropped_q <= dropped_d;
        end
    end

    assign dropped_cnt = dropped_q;
`else
    assign dropped_cnt = 16'h0;
`endif

    gps_word_fifo #(
        .WIDTH (PACK_WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push_q),
        .push_data (word_q),
        .full      (fifo_full),
        .pop       (fifo_pop),
        .pop_data  (m_data),
        .empty     (fifo_empty),
        .count     (fill_level)
    );

    assign m_valid  = !fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_gps_sample_packer.sv
// Bench for gps_sample_packer: DECIM=1 and DECIM=4 instances share stimulus, checked against a queue model.
module tb_gps_sample_packer;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic [2:0] real_in;
    logic [2:0] imag_in;
    logic       m_ready;
    logic       overflow_clr;

    logic [31:0] m_data_w  [2];
    logic        m_valid_w [2];
    logic [4:0]  fill_w    [2];
    logic        ovf_w     [2];
    logic [15:0] drp_w     [2];

    always #5 clk = ~clk;

    gps_sample_packer #(.DECIM(1), .FIFO_DEPTH(DEPTH)) u_d1 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .real_in      (real_in),
        .imag_in      (imag_in),
        .m_data       (m_data_w[0]),
        .m_valid      (m_valid_w[0]),
        .m_ready      (m_ready),
        .fill_level   (fill_w[0]),
        .overflow     (ovf_w[0]),
        .overflow_clr (overflow_clr),
        .dropped_cnt  (drp_w[0])
    );

    gps_sample_packer #(.DECIM(4), .FIFO_DEPTH(DEPTH)) u_d4 (
        .clk          (clk),
        .rst          (rst),
        .enable       (enable),
        .real_in      (real_in),
        .imag_in      (imag_in),
        .m_data       (m_data_w[1]),
        .m_valid      (m_valid_w[1]),
        .m_ready      (m_ready),
        .fill_level   (fill_w[1]),
        .overflow     (ovf_w[1]),
        .overflow_clr (overflow_clr),
        .dropped_cnt  (drp_w[1])
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: circular word store, list of kept samples, pending completed word.
    logic [31:0] mem [2][DEPTH];
    int          head [2];
    int          cnt  [2];
    int          idx  [2];
    int          pcnt [2];
    int          seq  [2];
    int          drp  [2];
    logic [5:0]  part [2][5];
    bit          pend [2];
    bit          ovf  [2];
    logic [31:0] pend_word [2];

    function automatic int decim_of(input int d);
        return (d == 0) ? 1 : 4;
    endfunction

    function automatic logic [31:0] exp_drop(input int d);
`ifdef GPS_PACKER_STATS_EN
        return 32'(drp[d]);
`else
        return (d < 0) ? 32'hFFFF_FFFF : 32'h0;
`endif
    endfunction

    task automatic model_edge(input int d);
        bit          pop;
        bit          drop;
        logic [31:0] w;
        if (rst) begin
            head[d] = 0; cnt[d] = 0; idx[d] = 0; pcnt[d] = 0;
            seq[d] = 0; drp[d] = 0; pend[d] = 0; ovf[d] = 0;
            return;
        end
        pop  = (cnt[d] > 0) && m_ready;
        drop = pend[d] && (cnt[d] == DEPTH) && !pop;
        if (pop) begin
            head[d] = (head[d] + 1) % DEPTH;
            cnt[d]  = cnt[d] - 1;
        end
        if (pend[d] && !drop) begin
            mem[d][(head[d] + cnt[d]) % DEPTH] = pend_word[d];
            cnt[d] = cnt[d] + 1;
        end
        if (drop) begin
            ovf[d] = 1'b1;
            if (drp[d] < 65535) drp[d] = drp[d] + 1;
        end else if (overflow_clr) begin
            ovf[d] = 1'b0;
        end
        pend[d] = 1'b0;
        if (enable) begin
            if (idx[d] % decim_of(d) == 0) begin
                part[d][pcnt[d]] = {imag_in, real_in};
                pcnt[d] = pcnt[d] + 1;
                if (pcnt[d] == 5) begin
                    w = 32'(seq[d]) << 30;
                    for (int k = 0; k < 5; k++) w = w | (32'(part[d][k]) << (6 * k));
                    pend_word[d] = w;
                    pend[d]      = 1'b1;
                    seq[d]       = (seq[d] + 1) % 4;
                    pcnt[d]      = 0;
                end
            end
            idx[d] = idx[d] + 1;
        end else begin
            idx[d]  = 0;
            pcnt[d] = 0;
        end
    endtask

    task automatic chk(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, d, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge(0);
        model_edge(1);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("m_valid", d, 32'(m_valid_w[d]), 32'(cnt[d] > 0));
            chk("m_data", d, m_data_w[d], (cnt[d] > 0) ? mem[d][head[d]] : 32'h0);
            chk("fill_level", d, 32'(fill_w[d]), 32'(cnt[d]));
            chk("overflow", d, 32'(ovf_w[d]), 32'(ovf[d]));
            chk("dropped_cnt", d, 32'(drp_w[d]), exp_drop(d));
        end
    endtask

    task automatic rand_data();
        real_in = 3'($urandom);
        imag_in = 3'($urandom);
    endtask

    initial begin
        logic [5:0]  smp [20];
        logic [31:0] exp_word;
        int          stage;

        rst = 1'b1; enable = 1'b1; m_ready = 1'b0; overflow_clr = 1'b0;
        real_in = '0; imag_in = '0;

        // Reset held with enable high.
        for (int i = 0; i < 3; i++) begin
            rand_data();
            step();
        end
        chk("rst_valid", 0, 32'(m_valid_w[0]), 32'h0);
        chk("rst_fill", 0, 32'(fill_w[0]), 32'h0);
        chk("rst_ovf", 1, 32'(ovf_w[1]), 32'h0);
        rst = 1'b0; enable = 1'b0;
        step();

        // Ramp pattern, DECIM=1 latency and content.
        m_ready = 1'b1; enable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            real_in = 3'(k);
            imag_in = ~3'(k);
            step();
            if (k == 4) chk("lat_lo", 0, 32'(m_valid_w[0]), 32'h0);
            if (k == 5) begin
                chk("lat_hi", 0, 32'(m_valid_w[0]), 32'h1);
                chk("word0", 0, m_data_w[0], 32'h1C8E_AC78);
            end
        end
        enable = 1'b0;
        step();
        chk("word1_seq", 0, 32'(m_data_w[0][31:30]), 32'h1);
        for (int i = 0; i < 3; i++) step();

        // DECIM=4 keeps samples 0,4,8,12,16.
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_data();
            smp[i] = {imag_in, real_in};
            step();
            if (i == 17) begin
                exp_word = {2'd0, smp[16], smp[12], smp[8], smp[4], smp[0]};
                chk("decim_valid", 1, 32'(m_valid_w[1]), 32'h1);
                chk("decim_word", 1, m_data_w[1], exp_word);
            end
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Back-pressure until the FIFO overflows by two words.
        m_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 5 * (DEPTH + 2); i++) begin
            rand_data();
            step();
        end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("full_fill", 0, 32'(fill_w[0]), 32'd16);
        chk("full_ovf", 0, 32'(ovf_w[0]), 32'h1);
`ifdef GPS_PACKER_STATS_EN
        chk("full_drops", 0, 32'(drp_w[0]), 32'd2);
`else
        chk("full_drops", 0, 32'(drp_w[0]), 32'd0);
`endif
        m_ready = 1'b1;
        for (int i = 0; i < 20; i++) step();
        overflow_clr = 1'b1;
        step();
        overflow_clr = 1'b0;
        chk("ovf_clr", 0, 32'(ovf_w[0]), 32'h0);

        // Enable dropped mid-word, then resumed.
        enable = 1'b1;
        for (int i = 0; i < 3; i++) begin rand_data(); step(); end
        enable = 1'b0;
        for (int i = 0; i < 2; i++) step();
        enable = 1'b1;
        for (int i = 0; i < 5; i++) begin rand_data(); step(); end
        enable = 1'b0;
        for (int i = 0; i < 3; i++) step();

        // Fill, then push-with-pop while full, then drop with a same-cycle clear.
        m_ready = 1'b0; enable = 1'b1;
        for (int i = 0; i < 5 * DEPTH; i++) begin rand_data(); step(); end
        stage = 0;
        for (int i = 0; i < 40 && stage < 2; i++) begin
            rand_data();
            m_ready      = 1'b0;
            overflow_clr = 1'b0;
            if (pend[0] && cnt[0] == DEPTH) begin
                if (stage == 0) m_ready = 1'b1;
                else overflow_clr = 1'b1;
            end
            step();
            if (m_ready) begin
                chk("pushpop_fill", 0, 32'(fill_w[0]), 32'd16);
                chk("pushpop_ovf", 0, 32'(ovf_w[0]), 32'h0);
                stage = 1;
            end else if (overflow_clr) begin
                chk("clr_vs_set", 0, 32'(ovf_w[0]), 32'h1);
                stage = 2;
            end
        end
        chk("full_phase_done", 0, 32'(stage), 32'd2);
        overflow_clr = 1'b0; m_ready = 1'b1; enable = 1'b0;
        for (int i = 0; i < 20; i++) step();

        // Random traffic with a mid-run reset.
        for (int i = 0; i < 400; i++) begin
            rand_data();
            enable       = ($urandom_range(0, 9) != 0);
            m_ready      = ($urandom_range(0, 2) != 0);
            overflow_clr = ($urandom_range(0, 15) == 0);
            rst          = (i == 200);
            step();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
